// File: rtl/systolic_array_param_pkg.sv
// rtl/systolic_array_param_pkg.sv - shared types and defaults for the systolic matrix multiplier
// Purpose: job FSM state encoding and default array geometry.
// Ports: none (package).
package systolic_array_param_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int DEF_N  = 4;
   localparam int DEF_DW = 8;

endpackage

// File: rtl/systolic_array_param_if.sv
// rtl/systolic_array_param_if.sv - job control, operand load and result bundle
// Purpose: groups the job handshake, operand beats and the accumulator view.
// Ports (signals): start, acc_mode, in_valid, a_col[N*DW], b_row[N*DW] toward the array;
//                  in_ready, busy, done, c_out[N*N*ACCW] from the array.
interface systolic_array_param_if
   import systolic_array_param_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int DW   = DEF_DW,
   parameter int ACCW = 2*DW + $clog2(N) + 2
);
   logic                start;
   logic                acc_mode;
   logic                in_valid;
   logic                in_ready;
   logic [N*DW-1:0]     a_col;
   logic [N*DW-1:0]     b_row;
   logic                busy;
   logic                done;
   logic [N*N*ACCW-1:0] c_out;

   modport master (
      output start, acc_mode, in_valid, a_col, b_row,
      input  in_ready, busy, done, c_out
   );

   modport slave (
      input  start, acc_mode, in_valid, a_col, b_row,
      output in_ready, busy, done, c_out
   );
endinterface

// File: rtl/pe_booth_mac.sv
// rtl/pe_booth_mac.sv - processing element: radix-4 Booth multiply and wrap-around accumulate
// Purpose: forwards a east and b south with one register each, adds a_in*b_in to acc every edge.
// Ports: clk, reset (sync, active-high), clr (zero accumulator), a_in/b_in (signed DW),
//        a_out/b_out (registered pass-through), acc (signed ACCW running sum).
module pe_booth_mac #(
   parameter int DW   = 8,
   parameter int ACCW = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic signed [DW-1:0]   a_in,
   input  logic signed [DW-1:0]   b_in,
   output logic signed [DW-1:0]   a_out,
   output logic signed [DW-1:0]   b_out,
   output logic signed [ACCW-1:0] acc
);

   // Recoded multiplier digits from overlapping bit triplets; partial products are
   // formed at full product width so the wrapped sum equals the exact product.
   function automatic logic signed [2*DW-1:0] booth_mul(input logic signed [DW-1:0] a,
                                                        input logic signed [DW-1:0] b);
      logic signed [2*DW-1:0] a_ext;
      logic signed [2*DW-1:0] pp;
      logic signed [2*DW-1:0] sum;
      logic [DW:0]            bx;
      logic [2:0]             trip;
      a_ext = {{DW{a[DW-1]}}, a};
      bx    = {b, 1'b0};
      sum   = '0;
      for (int g = 0; g < DW/2; g++) begin
         trip = bx[2*g +: 3];
         case (trip)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext <<< 1;
            3'b100:         pp = -(a_ext <<< 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
         endcase
         sum = sum + (pp <<< (2*g));
      end
      return sum;
   endfunction

   logic signed [DW-1:0]   a_q;
   logic signed [DW-1:0]   b_q;
   logic signed [ACCW-1:0] acc_q;
   logic signed [ACCW-1:0] acc_d;
   logic signed [2*DW-1:0] prod;

   always_comb begin
      prod  = booth_mul(a_in, b_in);
      acc_d = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_in;
         b_q   <= b_in;
         acc_q <= clr ? '0 : acc_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_param.sv
// rtl/systolic_array_param.sv - NxN output-stationary systolic multiplier, C = A x B
// Purpose: job FSM (IDLE/LOAD/DRAIN), beat and drain counters, operand skew, PE grid.
// Ports: clk, reset (sync, active-high), bus (slave): start/acc_mode job control,
//        in_valid/in_ready with a_col/b_row operand beats, busy/done status, c_out results.
module systolic_array_param
   import systolic_array_param_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int DW   = DEF_DW,
   parameter int ACCW = 2*DW + $clog2(N) + 2
) (
   input logic                   clk,
   input logic                   reset,
   systolic_array_param_if.slave bus
);

   localparam int BEAT_W = $clog2(N);
   localparam int DRN_W  = $clog2(2*N-1);

   state_e             state_q, state_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic               done_q, done_d;
   logic               clr;
   logic               accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         drn_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         drn_q   <= drn_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      drn_d   = drn_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      accept  = (state_q == ST_LOAD) && bus.in_valid;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               beat_d  = '0;
               clr     = !bus.acc_mode;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               if (beat_q == BEAT_W'(N-1)) begin
                  state_d = ST_DRAIN;
                  drn_d   = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Last beat reaches PE(N-1,N-1) 2N-2 edges after acceptance; done follows one edge later.
            if (drn_q == DRN_W'(2*N-2)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               drn_d = drn_q + DRN_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready = (state_q == ST_LOAD);
   assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
   assign bus.done     = done_q;

   logic signed [DW-1:0]   a_h   [N][N+1];
   logic signed [DW-1:0]   b_v   [N+1][N];
   logic signed [ACCW-1:0] acc_w [N][N];
   logic [N*N*ACCW-1:0]    c_flat;

   // Lane l is delayed l registers so A[i][k] and B[k][j] meet at PE(i,j) on the same edge.
   // Non-accepted cycles feed zeros, which add nothing downstream.
   for (genvar l = 0; l < N; l++) begin : g_skew
      logic signed [DW-1:0] a_lane;
      logic signed [DW-1:0] b_lane;
      assign a_lane = accept ? bus.a_col[l*DW +: DW] : '0;
      assign b_lane = accept ? bus.b_row[l*DW +: DW] : '0;
      if (l == 0) begin : g_d0
         assign a_h[l][0] = a_lane;
         assign b_v[0][l] = b_lane;
      end else begin : g_dn
         logic signed [DW-1:0] a_sr_q [l];
         logic signed [DW-1:0] b_sr_q [l];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < l; s++) begin
                  a_sr_q[s] <= '0;
                  b_sr_q[s] <= '0;
               end
            end else begin
               a_sr_q[0] <= a_lane;
               b_sr_q[0] <= b_lane;
               for (int s = 1; s < l; s++) begin
                  a_sr_q[s] <= a_sr_q[s-1];
                  b_sr_q[s] <= b_sr_q[s-1];
               end
            end
         end
         assign a_h[l][0] = a_sr_q[l-1];
         assign b_v[0][l] = b_sr_q[l-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         pe_booth_mac #(.DW(DW), .ACCW(ACCW)) u_pe (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .a_in  (a_h[i][j]),
            .b_in  (b_v[i][j]),
            .a_out (a_h[i][j+1]),
            .b_out (b_v[i+1][j]),
            .acc   (acc_w[i][j])
         );
         assign c_flat[(i*N+j)*ACCW +: ACCW] = acc_w[i][j];
      end
   end

   assign bus.c_out = c_flat;

endmodule
